finish_sequencer: RTL
=====================

FINISH_SEQUENCER -- requirements
Module: finish_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, cycles allowed from first ready edge to completion (used only with FINISH_SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port req_ready  input  NUM_REQ  per-requester ready level; a 0->1 transition is a completion report.
REQ-006 SHALL have port report_ack  input  1  shared report channel accepted the granted report.
REQ-007 SHALL have port grant  output  NUM_REQ  one-hot grant of the shared report channel; all-zero when idle.
REQ-008 SHALL have port all_finished  output  1  every requester reported and was acknowledged.
REQ-009 SHALL have port timed_out  output  1  timeout expired before completion.
REQ-010 SHALL have port seen  output  NUM_REQ  acknowledged-requester bitmap.

Function
REQ-011 SHALL detect rising edges per requester as req_ready=1 with registered previous value=0, sampled at posedge clk.
REQ-012 SHALL set pending[i] on the edge where a rising edge of requester i is detected, unless seen[i] or grant[i] is already 1; only the first report per requester counts.
REQ-013 SHALL capture simultaneous rising edges from several requesters on the same cycle without loss.
REQ-014 SHALL implement FSM states IDLE, WAIT_ACK, DONE, FAIL.
REQ-015 SHALL, in IDLE with pending nonzero, register grant to the round-robin winner and move to WAIT_ACK on the next edge; an edge pending at cycle k yields grant visible after edge k+1.
REQ-016 SHALL select the winner as the first pending index at or after rr_ptr, wrapping from NUM_REQ-1 to 0; rr_ptr resets to 0.
REQ-017 SHALL hold grant stable in WAIT_ACK until report_ack=1 is sampled.
REQ-018 SHALL, on report_ack in WAIT_ACK: clear grant and pending for that index, set seen for it, set rr_ptr to winner+1 (mod NUM_REQ), and go to DONE if seen becomes all-ones, else IDLE (one bubble cycle between grants).
REQ-019 SHALL ignore report_ack outside WAIT_ACK.
REQ-020 SHALL hold all_finished=1 in DONE; DONE and FAIL are terminal until reset, and no grants are issued from them.
REQ-021 SHALL keep grant one-hot or zero at all times.

Reset
REQ-022 SHALL, on rst assertion at any time (including mid-grant or in DONE/FAIL), immediately clear grant, pending, seen, edge-detect registers, rr_ptr, timeout counter, all_finished and timed_out, and enter IDLE.
REQ-023 SHALL load edge-detect registers with 0 on reset, so a req_ready already high at reset release counts as a rising edge on the first clock.

Configuration
REQ-024 SHALL, with macro FINISH_SEQ_TIMEOUT_EN defined, start a counter at the first detected rising edge, increment it every cycle outside DONE/FAIL, and on reaching TIMEOUT_CYCLES enter FAIL with timed_out=1 and grant cleared; expiry on the same edge as the final ack gives DONE priority.
REQ-025 SHALL, without FINISH_SEQ_TIMEOUT_EN, contain no counter, tie timed_out to 0, and make FAIL unreachable.

Structure
REQ-026 SHALL place the FSM state enum, the NUM_REQ upper bound and the counter-width function in shared package finish_seq_pkg.
REQ-027 SHALL implement winner selection in sub-module rr_arbiter (inputs pending and rr_ptr, output one-hot winner, combinational).

Verification
REQ-028 Bench SHALL drive req_ready[2] 0->1 at cycle 3 and ack 2 cycles after grant -> grant=4'b0100 after edge 4, seen=4'b0100 after ack, all_finished=0.
REQ-029 Bench SHALL raise all four req_ready on the same cycle with immediate acks -> grants in order 0,1,2,3 with one idle cycle between grants, then all_finished=1.
REQ-030 Bench SHALL toggle req_ready[1] 0->1->0->1 after it is acknowledged -> no second grant to 1, seen[1] stays 1.
REQ-031 Bench SHALL assert rst while in WAIT_ACK with grant=4'b0010 -> grant=0, seen=0, state IDLE before the next clk edge.
REQ-032 Bench (FINISH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64) SHALL report only requesters 0..2 -> timed_out=1 exactly 64 cycles after the first edge, all_finished=0, grant=0.
REQ-033 Bench SHALL hold report_ack=1 continuously with no pending -> no grant, seen=0.

Source files
------------

// File: rtl/finish_seq_pkg.sv
// finish_seq_pkg: shared definitions for the finish sequencer.
//   seq_state_e  : sequencer FSM states (S_DONE and S_FAIL are terminal)
//   MAX_REQ      : largest supported requester count
//   cnt_width()  : register width able to hold the values 0..n-1 (minimum 1)
package finish_seq_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_DONE,
    S_FAIL
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/finish_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over the pending bitmap.
//   pending [NUM_REQ-1:0] : requesters waiting for the report channel
//   rr_ptr  [PTR_W-1:0]   : index searched first
//   winner  [NUM_REQ-1:0] : one-hot first pending index at/after rr_ptr,
//                           wrapping to 0; all-zero if nothing pending
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] hi_pick;
  logic [NUM_REQ-1:0] lo_pick;
  logic               hi_found;
  logic               lo_found;

  // Wrap-around search split into two linear scans: the first pending index
  // at/after the pointer wins; otherwise the lowest pending index wins.
  always_comb begin
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (pending[j] && (j >= 32'(rr_ptr)) && !hi_found) begin
        hi_pick[j] = 1'b1;
        hi_found   = 1'b1;
      end
      if (pending[j] && !lo_found) begin
        lo_pick[j] = 1'b1;
        lo_found   = 1'b1;
      end
    end
    winner = hi_found ? hi_pick : lo_pick;
  end

endmodule

// File: rtl/finish_sequencer.sv
// finish_sequencer: collects one completion report (rising edge of
// req_ready) per requester and serialises them over a shared report channel
// with round-robin grants.
//   clk, rst      : clock; asynchronous active-high reset
//   req_ready     : per-requester ready level, 0->1 is a completion report
//   report_ack    : report channel accepted the granted report
//   grant         : one-hot grant of the report channel, zero when idle
//   all_finished  : every requester has been acknowledged
//   timed_out     : completion did not happen within TIMEOUT_CYCLES
//   seen          : acknowledged-requester bitmap
// Optional macro FINISH_SEQ_TIMEOUT_EN adds the completion timeout; without
// it timed_out is tied low and S_FAIL is unreachable.
module finish_sequencer #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_ready,
  input  logic               report_ack,
  output logic [NUM_REQ-1:0] grant,
  output logic               all_finished,
  output logic               timed_out,
  output logic [NUM_REQ-1:0] seen
);

  import finish_seq_pkg::*;

  localparam int unsigned PTR_W = cnt_width(NUM_REQ);

  seq_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] seen_q, seen_d;
  logic [NUM_REQ-1:0] prev_q;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] winner;
  int unsigned        ack_idx;

`ifdef FINISH_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner)
  );

  always_comb begin
    rise      = req_ready & ~prev_q;
    state_d   = state_q;
    grant_d   = grant_q;
    seen_d    = seen_q;
    rr_ptr_d  = rr_ptr_q;
    // Only the first report per requester counts.
    pending_d = pending_q | (rise & ~seen_q & ~grant_q);
    ack_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) ack_idx = k;
    end

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          grant_d = winner;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (report_ack) begin
          grant_d   = '0;
          pending_d = pending_d & ~grant_q;
          seen_d    = seen_q | grant_q;
          rr_ptr_d  = PTR_W'((ack_idx + 1) % NUM_REQ);
          state_d   = (&seen_d) ? S_DONE : S_IDLE;
        end
      end
      default: ;
    endcase

`ifdef FINISH_SEQ_TIMEOUT_EN
    started_d = started_q;
    cnt_d     = cnt_q;
    expire    = 1'b0;
    if ((state_q == S_IDLE) || (state_q == S_WAIT_ACK)) begin
      if (started_q) begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) expire = 1'b1;
        else                                     cnt_d  = cnt_q + 1'b1;
      end else if (|rise) begin
        started_d = 1'b1;
      end
    end
    // A final ack on the expiry edge still completes.
    if (expire && (state_d != S_DONE)) begin
      state_d = S_FAIL;
      grant_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      seen_q    <= '0;
      prev_q    <= '0;
      rr_ptr_q  <= '0;
`ifdef FINISH_SEQ_TIMEOUT_EN
      started_q <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      seen_q    <= seen_d;
      prev_q    <= req_ready;
      rr_ptr_q  <= rr_ptr_d;
`ifdef FINISH_SEQ_TIMEOUT_EN
      started_q <= started_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign seen         = seen_q;
  assign all_finished = (state_q == S_DONE);
`ifdef FINISH_SEQ_TIMEOUT_EN
  assign timed_out    = (state_q == S_FAIL);
`else
  assign timed_out    = 1'b0;
`endif

endmodule
